// File: rtl/gate_eval_pkg.sv
// Shared types and helpers for gate_eval_arbiter: gate type codes, pipeline
// stage records sized for the widest supported configuration, time arithmetic.
package gate_eval_pkg;

    localparam int MAX_TW   = 32;
    localparam int MAX_TAGW = 32;
    localparam int MAX_SRCW = 3;

    typedef enum logic [1:0] {
        NOT1  = 2'd0,
        NAND2 = 2'd1,
        NOR2  = 2'd2,
        RSVD  = 2'd3
    } gate_type_e;

    typedef struct packed {
        gate_type_e            typ;
        logic                  a;
        logic                  b;
        logic [MAX_TW-1:0]     ta;
        logic [MAX_TW-1:0]     tb;
        logic [MAX_TAGW-1:0]   tag;
        logic [MAX_SRCW-1:0]   src;
    } s1_t;

    typedef struct packed {
        gate_type_e            typ;
        logic                  err;
        logic                  val;
        logic [MAX_TW-1:0]     t;
        logic [MAX_TAGW-1:0]   tag;
        logic [MAX_SRCW-1:0]   src;
    } s2_t;

    // Adds a delay to an arrival time, clamping at the largest tw-bit value.
    function automatic logic [MAX_TW-1:0] sat_add(
        input logic [MAX_TW-1:0] a,
        input logic [MAX_TW-1:0] d,
        input int unsigned       tw
    );
        logic [MAX_TW:0] sum;
        logic [MAX_TW:0] lim;
        sum = {1'b0, a} + {1'b0, d};
        lim = ({{MAX_TW{1'b0}}, 1'b1} << tw) - {{MAX_TW{1'b0}}, 1'b1};
        sat_add = (sum > lim) ? lim[MAX_TW-1:0] : sum[MAX_TW-1:0];
    endfunction

    function automatic logic [MAX_TW-1:0] tmax(
        input logic [MAX_TW-1:0] a,
        input logic [MAX_TW-1:0] b
    );
        tmax = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_eval_arbiter_if.sv
// Request/result bundle between traversal engines (master) and the
// shared gate evaluation engine (slave).
interface gate_eval_arbiter_if #(
    parameter int NREQ = 4,
    parameter int TW   = 16,
    parameter int TAGW = 8
);
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_type;
    logic [NREQ-1:0]      req_a;
    logic [NREQ-1:0]      req_b;
    logic [TW*NREQ-1:0]   req_ta;
    logic [TW*NREQ-1:0]   req_tb;
    logic [TAGW*NREQ-1:0] req_tag;
    logic                 res_valid;
    logic                 res_ready;
    logic                 res_val;
    logic [TW-1:0]        res_time;
    logic [TAGW-1:0]      res_tag;
    logic [SW-1:0]        res_src;
    logic                 res_err;

    modport master (
        output req_valid, req_type, req_a, req_b, req_ta, req_tb, req_tag, res_ready,
        input  req_ready, res_valid, res_val, res_time, res_tag, res_src, res_err
    );

    modport slave (
        input  req_valid, req_type, req_a, req_b, req_ta, req_tb, req_tag, res_ready,
        output req_ready, res_valid, res_val, res_time, res_tag, res_src, res_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first requester at or after ptr (wrapping),
// and returns the pointer to use next cycle.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [SW-1:0]   grant_idx,
    output logic [SW-1:0]   next_ptr
);
    logic found_s;
    logic hit_s;

    // Scan requesters starting from ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx        = (int'(ptr) + k) % NREQ;
            hit_s      = req[idx] & ~found_s;
            grant[idx] = hit_s;
            grant_idx  = hit_s ? SW'(idx) : grant_idx;
            found_s    = found_s | hit_s;
        end
        next_ptr = (advance & found_s)
                 ? ((int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + SW'(1))
                 : ptr;
    end

endmodule

// File: rtl/gate_eval_arbiter.sv
// Round-robin front end plus two-stage evaluator for NOT1/NAND2/NOR2 cells.
// Optional per-type result counters are built when GATE_EVAL_STATS_EN is defined.
module gate_eval_arbiter
    import gate_eval_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TW    = 16,
    parameter int TAGW  = 8,
    parameter int DELAY = 1
) (
    input  logic                clk,
    input  logic                rst,
    gate_eval_arbiter_if.slave  bus,
    input  logic [1:0]          stat_sel,
    output logic [31:0]         stat_cnt
);
    localparam int SW = $clog2(NREQ);
    localparam logic [MAX_TW-1:0] DLY = MAX_TW'(DELAY);

    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;
    s1_t             s1_q, s1_d, s1_new_s;
    s2_t             s2_q, s2_d, s2_new_s;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] grant_s;
    logic [SW-1:0]   gidx_s;
    logic [SW-1:0]   next_ptr_s;
    logic            s1_load_s;
    logic            s2_load_s;
    logic [NREQ-1:0] req_ready_s;
    logic            accept_s;

    rr_arbiter #(.NREQ(NREQ), .SW(SW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .advance   (accept_s),
        .grant     (grant_s),
        .grant_idx (gidx_s),
        .next_ptr  (next_ptr_s)
    );

    // Stall chain: each stage loads when empty or when its contents move on.
    always_comb begin
        s2_load_s   = ~s2_valid_q | bus.res_ready;
        s1_load_s   = ~s1_valid_q | s2_load_s;
        req_ready_s = grant_s & {NREQ{s1_load_s & ~rst}};
        accept_s    = |req_ready_s;
    end

    // Capture the granted requester's fields into a stage-1 record.
    always_comb begin
        s1_new_s              = '0;
        s1_new_s.typ          = gate_type_e'(bus.req_type[int'(gidx_s)*2 +: 2]);
        s1_new_s.a            = bus.req_a[gidx_s];
        s1_new_s.b            = bus.req_b[gidx_s];
        s1_new_s.ta[TW-1:0]   = bus.req_ta[int'(gidx_s)*TW +: TW];
        s1_new_s.tb[TW-1:0]   = bus.req_tb[int'(gidx_s)*TW +: TW];
        s1_new_s.tag[TAGW-1:0] = bus.req_tag[int'(gidx_s)*TAGW +: TAGW];
        s1_new_s.src[SW-1:0]  = gidx_s;
    end

    // Cell evaluation: logic value and saturating worst-case arrival.
    always_comb begin
        s2_new_s     = '0;
        s2_new_s.typ = s1_q.typ;
        s2_new_s.tag = s1_q.tag;
        s2_new_s.src = s1_q.src;
        case (s1_q.typ)
            NOT1: begin
                s2_new_s.val = ~s1_q.a;
                s2_new_s.t   = sat_add(s1_q.ta, DLY, TW);
            end
            NAND2: begin
                s2_new_s.val = ~(s1_q.a & s1_q.b);
                s2_new_s.t   = sat_add(tmax(s1_q.ta, s1_q.tb), DLY, TW);
            end
            NOR2: begin
                s2_new_s.val = ~(s1_q.a | s1_q.b);
                s2_new_s.t   = sat_add(tmax(s1_q.ta, s1_q.tb), DLY, TW);
            end
            default: begin
                s2_new_s.err = 1'b1;
            end
        endcase
    end

    // Next-state for both stages and the round-robin pointer.
    always_comb begin
        s1_valid_d = s1_load_s ? accept_s : s1_valid_q;
        s1_d       = accept_s ? s1_new_s : s1_q;
        s2_valid_d = s2_load_s ? s1_valid_q : s2_valid_q;
        s2_d       = (s2_load_s & s1_valid_q) ? s2_new_s : s2_q;
        rr_ptr_d   = next_ptr_s;
    end

    // Pipeline and pointer registers; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.res_valid = s2_valid_q;
    assign bus.res_val   = s2_q.val;
    assign bus.res_time  = s2_q.t[TW-1:0];
    assign bus.res_tag   = s2_q.tag[TAGW-1:0];
    assign bus.res_src   = s2_q.src[SW-1:0];
    assign bus.res_err   = s2_q.err;

    logic unused_s;
    assign unused_s = ^{s2_q};

`ifdef GATE_EVAL_STATS_EN
    logic [31:0] cnt_q [4];
    logic [31:0] cnt_d [4];
    logic [1:0]  typ_s;
    logic        inc_s;

    assign typ_s = s2_q.typ;

    // Count accepted results per type code, holding at all-ones.
    always_comb begin
        inc_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inc_s    = s2_valid_q & bus.res_ready & (typ_s == 2'(i))
                     & (cnt_q[i] != 32'hFFFF_FFFF);
            cnt_d[i] = cnt_q[i] + {31'd0, inc_s};
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stat_cnt = cnt_q[stat_sel];
`else
    logic unused_sel_s;
    assign unused_sel_s = ^stat_sel;
    assign stat_cnt     = 32'd0;
`endif

endmodule

// File: doc/gate_eval_arbiter.md
# gate_eval_arbiter

Shared evaluation engine for the unit-delay cell library (NOT1, NAND2, NOR2) used by the timing-analysis flow. It takes gate-evaluation requests from NREQ traversal engines and arbitrates them round-robin onto one two-stage evaluation pipeline. For each granted request it produces the output logic value and the worst-case output arrival time, tagged for return to the originating requester.

## Interface
Parameters:
- NREQ, 4, number of requester ports (2..8).
- TW, 16, arrival-time width in time units (1 unit = 1 ns).
- TAGW, 8, request tag width.
- DELAY, 1, pin-to-output delay applied to every cell; equal for rise and fall.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_type  in  2*NREQ  per requester: 0 NOT1, 1 NAND2, 2 NOR2, 3 reserved.
- req_a, req_b  in  NREQ  input pin logic values; B is ignored for NOT1.
- req_ta, req_tb  in  TW*NREQ  input pin arrival times.
- req_tag  in  TAGW*NREQ  opaque tag.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_val  out  1  gate output logic value.
- res_time  out  TW  output arrival time.
- res_tag  out  TAGW  echoed tag.
- res_src  out  $clog2(NREQ)  index of the granted requester.
- res_err  out  1  reserved type seen.
- stat_sel  in  2  statistics counter select (type code).
- stat_cnt  out  32  selected statistics counter.

## Operation
- Arbitration is round-robin. rr_ptr resets to 0. The grant goes to the lowest index i ≥ rr_ptr (mod NREQ) with req_valid[i]. The handshake is req_ready[g] = grant & s1 can load. On accept, rr_ptr ← g+1 mod NREQ. With no accept, rr_ptr holds.
- Stage 1 (s1) registers type, values, times, tag, and source.
- Stage 2 (s2) is the output register: s2 ← f(s1).
- Logic values:
  - NOT1 = ~a.
  - NAND2 = ~(a&b).
  - NOR2 = ~(a|b).
- Arrival times:
  - NOT1: ta + DELAY.
  - NAND2 and NOR2: max(ta, tb) + DELAY.
  - The sum saturates at 2^TW−1, never wraps.
- Type 3: res_err=1, res_val=0, res_time=0, tag and src passed through.
- Flow control:
  - s2 loads when empty or when (res_valid & res_ready).
  - s1 loads when empty or when s1 advances into s2.
  - This is a full-throughput stall chain; no combinational path exists from res_ready to req_ready beyond this load-enable.
- Reset mid-operation: all in-flight requests are discarded, with no result emitted. Requesters must re-issue.

## Timing
- Latency is 2 cycles from the accepting edge (req_valid & req_ready) to res_valid, with no stall.
- Throughput is 1 result/cycle while res_ready=1.
- Reset values:
  - req_ready=0, res_valid=0, res_val=0, res_time=0, res_tag=0, res_src=0, res_err=0, stat_cnt=0.
  - rr_ptr=0; s1 and s2 empty.
- Output stability: res_* stay stable while res_valid & !res_ready.
- When both stages are full and stalled, req_ready is all zero.
- Requesters must hold their request fields while req_valid=1 and req_ready=0.

## Configuration
- GATE_EVAL_STATS_EN defined:
  - Four 32-bit counters, one per type code, each increments when a result of that type is accepted (res_valid & res_ready).
  - Counters saturate at all-ones and reset to 0.
  - stat_cnt = counter[stat_sel].
- Not defined: no counters are built and stat_cnt is tied to 0.

## Structure
- Package gate_eval_pkg holds:
  - the gate_type_e enum (NOT1=0, NAND2=1, NOR2=2, RSVD=3);
  - the s1/s2 stage struct;
  - the sat_add and tmax helper functions.
- Sub-module rr_arbiter (parameter NREQ) takes req, ptr, and advance, and produces a one-hot grant, grant index, and next ptr. The remainder is flat in gate_eval_arbiter.

## Test plan
- Reset, then a single NAND2 on port 0 (a=1, b=1, ta=3, tb=7, tag=0x11), res_ready=1 → after 2 cycles res_val=0, res_time=8, res_tag=0x11, res_src=0, res_err=0.
- All 4 ports valid continuously with res_ready=1 → grants 0,1,2,3,0,… one per cycle, and 8 results arrive in grant order.
- NOR2 with ta=0xFFFE and tb=0xFFFF (TW=16) → res_time=0xFFFF (saturated); NOT1 with ta=0xFFFF → 0xFFFF.
- Stall: hold res_ready=0 for 5 cycles with 3 requests pending → exactly 2 accepted, then req_ready=0 and res_* held stable; release → the remaining request is accepted and all 3 results arrive in order.
- Type 3 on port 2 → res_err=1, res_val=0, res_time=0, res_src=2; with GATE_EVAL_STATS_EN and stat_sel=3 → stat_cnt=1.
- Assert rst while s1 and s2 are full → res_valid=0 immediately (asynchronously), no stale result after release, rr_ptr=0.
